pll_lock_reset_seq: RTL
=======================

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on LOCKED_IN (minimum 2).
REQ-002 Parameter STABLE_CYCLES, default 1024: cycles LOCKED must stay high before the hold phase starts (minimum 1).
REQ-003 Parameter HOLD_CYCLES, default 16: extra cycles reset is held after lock is stable (minimum 1).
REQ-004 Parameter CNT_W, default 8: width of LOSS_CNT.
REQ-005 CLK  in  1  system clock (the PLL CLKHF output, 100 MHz); the only clock in the block.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 LOCKED_IN  in  1  PLL LOCKED, asynchronous to CLK.
REQ-008 FORCE_RST  in  1  synchronous request to re-run the sequence; level-sampled.
REQ-009 CLR_CNT  in  1  synchronous single-cycle clear of LOSS_CNT.
REQ-010 SYS_RST_N  out  1  registered active-low reset for the downstream TDC logic.
REQ-011 READY  out  1  registered; high only in RUN.
REQ-012 STATE  out  2  current state (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3).
REQ-013 LOSS_CNT  out  CNT_W  number of lock-loss events.

Function
REQ-014 LOCKED_IN shall pass through SYNC_STAGES flops to form lock_s; no other logic shall use LOCKED_IN.
REQ-015 WAIT_LOCK: counter held at 0; go to STABLE on the first edge where lock_s=1 and FORCE_RST=0.
REQ-016 STABLE: counter increments each cycle; if lock_s=0, go to WAIT_LOCK and clear the counter; at counter=STABLE_CYCLES-1, go to HOLD and clear the counter.
REQ-017 HOLD: counter increments; if lock_s=0, go to WAIT_LOCK; at counter=HOLD_CYCLES-1, go to RUN.
REQ-018 RUN: stay while lock_s=1 and FORCE_RST=0; otherwise go to WAIT_LOCK.
REQ-019 FORCE_RST=1 in any state shall force WAIT_LOCK on the next edge; it has priority over every other transition.
REQ-020 SYS_RST_N and READY shall rise on the same edge STATE becomes RUN and fall on the same edge STATE leaves RUN; there are no glitches and no intermediate values.
REQ-021 Latency: with LOCKED_IN held high and FORCE_RST=0, SYS_RST_N rises exactly SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges after the first edge that samples LOCKED_IN high; this is 1043 edges with the defaults.
REQ-022 A lock_s drop of any length, including a single cycle, in STABLE or HOLD shall restart qualification from WAIT_LOCK.
REQ-023 The counter width shall be clog2(max(STABLE_CYCLES,HOLD_CYCLES)); the counter shall never wrap.

Reset
REQ-024 While RST_N=0: STATE=WAIT_LOCK, counter=0, synchronizer=0, SYS_RST_N=0, READY=0, LOSS_CNT=0, all set asynchronously.
REQ-025 RST_N deassertion shall be synchronized internally with 2 flops; the FSM leaves WAIT_LOCK no earlier than the second edge after release.
REQ-026 Assertion of RST_N mid-sequence, including in RUN, shall abort immediately to the reset values.

Configuration
REQ-027 Macro LOCK_LOSS_CNT_EN, when defined: LOSS_CNT increments by 1 on each RUN->WAIT_LOCK transition caused by lock_s=0 (not by FORCE_RST).
REQ-028 With LOCK_LOSS_CNT_EN defined, LOSS_CNT saturates at 2^CNT_W-1.
REQ-029 With LOCK_LOSS_CNT_EN defined, CLR_CNT zeroes LOSS_CNT on the next edge; CLR_CNT and an increment on the same edge yield 1.
REQ-030 Macro LOCK_LOSS_CNT_EN, when undefined: the LOSS_CNT port remains, is driven constant 0, CLR_CNT is ignored, and no counter flops are inferred.

Verification
REQ-031 RST_N released, LOCKED_IN=1 from cycle 0, defaults -> SYS_RST_N and READY rise at edge 1043, STATE=3.
REQ-032 LOCKED_IN low for 1 cycle at STABLE count 500 -> STATE returns to 0, and SYS_RST_N rises 1043 edges after LOCKED_IN returns high.
REQ-033 In RUN, LOCKED_IN falls -> SYS_RST_N=0 within SYNC_STAGES+1 edges, and LOSS_CNT goes 0->1 (macro on) or stays 0 (macro off).
REQ-034 In RUN, FORCE_RST pulsed for 1 cycle -> STATE=0 next edge, SYS_RST_N low, LOSS_CNT unchanged, and the sequence re-runs with 1043-edge latency.
REQ-035 CNT_W=2, 4 lock losses with the macro on -> LOSS_CNT=3 (saturated); CLR_CNT coinciding with a 5th loss -> LOSS_CNT=1.
REQ-036 RST_N asserted during HOLD -> all outputs take reset values asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/pll_lock_reset_seq_if.sv
// pll_lock_reset_seq_if: control/status bundle for the PLL lock reset sequencer.
// The slave modport is the sequencer side; the master modport is the controller side.
`timescale 1ns/1ps
interface pll_lock_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             i_locked_in;  // PLL LOCKED, asynchronous to the clock
  logic             i_force_rst;  // level request to re-run the sequence
  logic             i_clr_cnt;    // single-cycle clear of the loss counter
  logic             o_sys_rst_n;  // registered active-low downstream reset
  logic             o_ready;      // high only in RUN
  logic [1:0]       o_state;      // WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3
  logic [CNT_W-1:0] o_loss_cnt;   // lock-loss events seen in RUN

  modport master (
    output i_locked_in, i_force_rst, i_clr_cnt,
    input  o_sys_rst_n, o_ready, o_state, o_loss_cnt
  );

  modport slave (
    input  i_locked_in, i_force_rst, i_clr_cnt,
    output o_sys_rst_n, o_ready, o_state, o_loss_cnt
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: holds downstream logic in reset until the PLL lock has been
// seen stable for STABLE_CYCLES and then for HOLD_CYCLES more, and drops reset
// back on lock loss, FORCE_RST or RST_N.
// Optional feature macro: LOCK_LOSS_CNT_EN enables the saturating lock-loss counter;
// without it LOSS_CNT is tied to 0 and CLR_CNT is ignored.
`timescale 1ns/1ps
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,     // >= 2
  parameter int STABLE_CYCLES = 1024,  // >= 1
  parameter int HOLD_CYCLES   = 16,    // >= 1
  parameter int CNT_W         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pll_lock_reset_seq_if.slave   bus
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // The counter only ever reaches max(STABLE,HOLD)-1, so clog2 of the max is enough.
  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CTR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(HOLD_CYCLES - 1);

  logic [1:0]             r_rst_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [1:0]             r_state;
  logic [CTR_W-1:0]       r_cnt;
  logic                   r_sys_rst_n;
  logic                   r_ready;

  logic                   w_lock_s;
  logic                   w_fsm_en;
  logic                   w_loss_evt;
  logic [1:0]             w_state_next;
  logic [CTR_W-1:0]       w_cnt_next;

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_fsm_en = r_rst_sync[1];

  // Reset release synchronizer: the FSM stays frozen until two edges after RST_N rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // LOCKED_IN synchronizer chain; nothing else looks at the raw input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lock_sync <= '0;
    else          r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.i_locked_in};
  end

  // Next-state logic: FORCE_RST beats everything, then lock loss, then count expiry.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_loss_evt   = 1'b0;
    if (bus.i_force_rst) begin
      w_state_next = ST_WAIT_LOCK;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_cnt_next = '0;
          if (w_lock_s) w_state_next = ST_STABLE;
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_next = ST_HOLD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CTR_W'(1);
          end
        end
        ST_HOLD: begin
          if (!w_lock_s) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CTR_W'(1);
          end
        end
        default: begin  // ST_RUN
          w_cnt_next = '0;
          if (!w_lock_s) begin
            w_state_next = ST_WAIT_LOCK;
            w_loss_evt   = w_fsm_en;
          end
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are decoded from the next state so they move with STATE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else if (w_fsm_en) begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sys_rst_n <= (w_state_next == ST_RUN);
      r_ready     <= (w_state_next == ST_RUN);
    end
  end

  assign bus.o_state     = r_state;
  assign bus.o_sys_rst_n = r_sys_rst_n;
  assign bus.o_ready     = r_ready;

`ifdef LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] r_loss_cnt;

  // Saturating lock-loss counter; a clear coinciding with a loss leaves exactly one count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loss_cnt <= '0;
    end else if (bus.i_clr_cnt) begin
      r_loss_cnt <= w_loss_evt ? CNT_W'(1) : '0;
    end else if (w_loss_evt && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + CNT_W'(1);
    end
  end

  assign bus.o_loss_cnt = r_loss_cnt;
`else
  logic w_unused;
  assign w_unused       = &{1'b0, w_loss_evt, bus.i_clr_cnt};
  assign bus.o_loss_cnt = '0;
`endif

endmodule
